// File: rtl/siha_pkg.sv
// Shared types and default constants for the slot reconfiguration sequencer.
package siha_pkg;

  localparam int SLOT_W           = 4;
  localparam int DEF_NUM_SLOTS    = 3;
  localparam int DEF_RESET_HOLD   = 16;
  localparam int DEF_WAIT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE,
    DECOUPLE,
    QUIESCE,
    WAIT_PR,
    CLK_ON,
    RST_HOLD,
    RECOUPLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating wait/hold counter: cleared on every state entry, flags when the
// count reaches the supplied limit.
module seq_wait_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= limit);

endmodule

// File: rtl/slot_reconfig_sequencer.sv
// Sequences decouple / quiesce / partial reconfig / clock / reset / recouple for
// one slot per request. Optional wait timeouts: define SLOT_SEQ_TIMEOUT_EN.
module slot_reconfig_sequencer
  import siha_pkg::*;
#(
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int RESET_HOLD   = DEF_RESET_HOLD,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetn,
  // Request handshake: a request transfers on a clk edge where req_valid and
  // req_ready are both high; req_ready is high only while idle.
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SLOT_W-1:0]    req_slot,
  input  logic                 pr_done,
  input  logic [NUM_SLOTS-1:0] rp_clk_locked,
  input  logic [NUM_SLOTS-1:0] decouple_status,
  output logic [NUM_SLOTS-1:0] decouple,
  output logic [NUM_SLOTS-1:0] slot_clken,
  output logic [NUM_SLOTS-1:0] slot_resetn,
  output logic                 done_valid,
  output logic                 done_err,
  output logic [SLOT_W-1:0]    done_slot,
  output logic                 busy,
  output seq_state_t           state_dbg
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] TMO_LIM  = CW'(WAIT_TIMEOUT - 1);

  seq_state_t            state;
  logic [SLOT_W-1:0]     slot_q;
  logic                  ready_q;
  logic [NUM_SLOTS-1:0]  sel_mask;
  logic [NUM_SLOTS-1:0]  req_mask;
  logic                  req_ok;
  logic                  status_sel;
  logic                  lock_sel;
  logic                  advance;
  logic                  timer_expired;
  logic                  timeout;

  assign sel_mask   = NUM_SLOTS'(1) << slot_q;
  assign req_mask   = NUM_SLOTS'(1) << req_slot;
  assign req_ok     = (req_slot < SLOT_W'(NUM_SLOTS));
  assign status_sel = |(decouple_status & sel_mask);
  assign lock_sel   = |(rp_clk_locked & sel_mask);

  assign req_ready  = ready_q && (state == IDLE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

`ifdef SLOT_SEQ_TIMEOUT_EN
  assign timeout = timer_expired &&
                   ((state == DECOUPLE) || (state == CLK_ON) || (state == RECOUPLE));
`else
  assign timeout = 1'b0;
`endif

  // advance is the exit condition of the current state; it also restarts the timer
  always_comb begin
    advance = 1'b0;
    case (state)
      IDLE:     advance = req_valid && ready_q;
      DECOUPLE: advance = status_sel || timeout;
      QUIESCE:  advance = 1'b1;
      WAIT_PR:  advance = pr_done;
      CLK_ON:   advance = lock_sel || timeout;
      RST_HOLD: advance = timer_expired;
      RECOUPLE: advance = !status_sel || timeout;
      DONE:     advance = 1'b1;
      default:  advance = 1'b1;
    endcase
  end

  seq_wait_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (advance),
    .enable  (1'b1),
    .limit   ((state == RST_HOLD) ? HOLD_LIM : TMO_LIM),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      slot_q      <= '0;
      ready_q     <= 1'b0;
      decouple    <= '0;
      slot_clken  <= '1;
      slot_resetn <= '1;
      done_valid  <= 1'b0;
      done_err    <= 1'b0;
      done_slot   <= '0;
    end else begin
      ready_q    <= 1'b1;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      if (advance) begin
        case (state)
          IDLE: begin
            slot_q <= req_slot;
            if (req_ok) begin
              state    <= DECOUPLE;
              decouple <= decouple | req_mask;
            end else begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              done_slot  <= req_slot;
            end
          end
          DECOUPLE: begin
            slot_resetn <= slot_resetn & ~sel_mask;
            if (status_sel) begin
              state <= QUIESCE;
            end else begin
              slot_clken <= slot_clken & ~sel_mask;
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              done_slot  <= slot_q;
            end
          end
          QUIESCE: begin
            slot_clken <= slot_clken & ~sel_mask;
            state      <= WAIT_PR;
          end
          WAIT_PR: begin
            slot_clken <= slot_clken | sel_mask;
            state      <= CLK_ON;
          end
          CLK_ON: begin
            if (lock_sel) begin
              state <= RST_HOLD;
            end else begin
              slot_clken <= slot_clken & ~sel_mask;
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              done_slot  <= slot_q;
            end
          end
          RST_HOLD: begin
            slot_resetn <= slot_resetn | sel_mask;
            decouple    <= decouple & ~sel_mask;
            state       <= RECOUPLE;
          end
          RECOUPLE: begin
            state      <= DONE;
            done_valid <= 1'b1;
            done_slot  <= slot_q;
            if (status_sel) begin
              // recouple never settled: park the slot isolated, in reset, clock off
              decouple    <= decouple | sel_mask;
              slot_resetn <= slot_resetn & ~sel_mask;
              slot_clken  <= slot_clken & ~sel_mask;
              done_err    <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slot_reconfig_sequencer.sv
// Directed bench for slot_reconfig_sequencer with a done-record scoreboard and
// behavioural decoupler / MMCM responders.
module tb_slot_reconfig_sequencer;
  import siha_pkg::*;

  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [SLOT_W-1:0] req_slot;
  logic              pr_done;
  logic [NS-1:0]     rp_clk_locked = '0;
  logic [NS-1:0]     decouple_status = '0;
  logic [NS-1:0]     decouple;
  logic [NS-1:0]     slot_clken;
  logic [NS-1:0]     slot_resetn;
  logic              done_valid;
  logic              done_err;
  logic [SLOT_W-1:0] done_slot;
  logic              busy;
  seq_state_t        state_dbg;

  logic [SLOT_W:0] exp_q[$];
  logic [SLOT_W:0] exp_rec;
  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int base;
  int n;

  logic [NS-1:0] sel_mask;
  logic [NS-1:0] lock_inhibit;
  logic          others_bad;

  slot_reconfig_sequencer #(.NUM_SLOTS(NS), .RESET_HOLD(16), .WAIT_TIMEOUT(1023)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_slot        (req_slot),
    .pr_done         (pr_done),
    .rp_clk_locked   (rp_clk_locked),
    .decouple_status (decouple_status),
    .decouple        (decouple),
    .slot_clken      (slot_clken),
    .slot_resetn     (slot_resetn),
    .done_valid      (done_valid),
    .done_err        (done_err),
    .done_slot       (done_slot),
    .busy            (busy),
    .state_dbg       (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // decoupler echoes decouple two cycles late; MMCM locks 5 cycles after clken
  logic [NS-1:0] d1 = '0;
  logic [NS-1:0] d2 = '0;
  int lock_cnt[NS] = '{default: 0};

  always @(posedge clk) begin
    #1;
    decouple_status = d2;
    d2 = d1;
    d1 = decouple;
    for (int i = 0; i < NS; i++) begin
      if (slot_clken[i] !== 1'b1) lock_cnt[i] = 0;
      else if (lock_cnt[i] < 5) lock_cnt[i]++;
      rp_clk_locked[i] = (lock_cnt[i] >= 5) && !lock_inhibit[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each done pulse pops one {err, slot} record
  always @(negedge clk) begin
    if (resetn === 1'b1 && done_valid === 1'b1) begin
      done_count++;
      check("done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_rec = exp_q.pop_front();
        check("done_err_slot", {done_err, done_slot}, exp_rec);
      end
    end
  end

  // slots outside sel_mask must sit at their idle values throughout
  always @(negedge clk) begin
    if (resetn === 1'b1 &&
        (((decouple & ~sel_mask) !== '0) || ((slot_clken | sel_mask) !== '1) ||
         ((slot_resetn | sel_mask) !== '1)))
      others_bad = 1'b1;
  end

  // driver tasks
  task automatic send_req(input logic [SLOT_W-1:0] s, input logic err);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_slot  = s;
    @(negedge clk);
    check("req_ready_before_accept", req_ready, 1);
    exp_q.push_back({err, s});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_pr();
    @(posedge clk); #1;
    pr_done = 1'b1;
    @(posedge clk); #1;
    pr_done = 1'b0;
  endtask

  task automatic wait_state(input seq_state_t s, input int budget, input string tag);
    int k = 0;
    while (state_dbg !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, state_dbg, s);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check({tag, "_ready_before_edge"}, req_ready, 0);
    @(negedge clk);
    check({tag, "_ready_after_edge"}, req_ready, 1);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_slot = '0; pr_done = 1'b0;
    sel_mask = '0; lock_inhibit = '0; others_bad = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_decouple", decouple, 0);
    check("rst_clken", slot_clken, 3'b111);
    check("rst_slot_resetn", slot_resetn, 3'b111);
    check("rst_done", {done_valid, done_err, done_slot}, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    release_reset("init");

    // full sequence on slot 1
    sel_mask = 3'b010; others_bad = 1'b0; base = done_count;
    send_req(1, 0);
    @(negedge clk);
    check("t1_decouple_on", decouple, 3'b010);
    check("t1_busy", busy, 1);
    check("t1_reset_untouched", slot_resetn, 3'b111);
    wait_state(QUIESCE, 10, "t1_reach_quiesce");
    check("t1_quiesce_reset_low", slot_resetn, 3'b101);
    check("t1_quiesce_clk_still_on", slot_clken, 3'b111);
    @(negedge clk);
    check("t1_wait_pr_state", state_dbg, WAIT_PR);
    check("t1_clk_off", slot_clken, 3'b101);
    repeat (15) @(posedge clk);
    check("t1_still_waiting_pr", state_dbg, WAIT_PR);
    pulse_pr();
    check("t1_clk_on_state", state_dbg, CLK_ON);
    check("t1_clk_back_on", slot_clken, 3'b111);
    n = 0;
    while (rp_clk_locked[1] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t1_lock_seen", rp_clk_locked[1], 1);
    repeat (16) @(negedge clk);
    check("t1_reset_low_cycle16", slot_resetn, 3'b101);
    @(negedge clk);
    check("t1_reset_released_cycle17", slot_resetn, 3'b111);
    check("t1_recouple", decouple, 3'b000);
    wait_state(IDLE, 20, "t1_back_idle");
    check("t1_one_done", done_count - base, 1);
    check("t1_others_stable", others_bad, 0);
    check("t1_final_outputs", {decouple, slot_clken, slot_resetn}, 9'b000_111_111);

    // out-of-range slot
    sel_mask = 3'b000; others_bad = 1'b0; base = done_count;
    send_req(5, 1);
    @(negedge clk);
    check("t2_done_next_cycle", {done_valid, done_err, done_slot}, {1'b1, 1'b1, 4'd5});
    @(negedge clk);
    check("t2_idle_again", {busy, done_valid}, 0);
    check("t2_one_done", done_count - base, 1);
    check("t2_outputs_unchanged", others_bad, 0);

    // pr_done during DECOUPLE must be ignored
    sel_mask = 3'b001; others_bad = 1'b0; base = done_count;
    send_req(0, 0);
    pr_done = 1'b1;
    @(posedge clk); #1;
    pr_done = 1'b0;
    check("t3_pulse_in_decouple", state_dbg, DECOUPLE);
    wait_state(WAIT_PR, 20, "t3_reach_wait_pr");
    repeat (10) @(negedge clk);
    check("t3_early_pr_ignored", state_dbg, WAIT_PR);
    pulse_pr();
    check("t3_second_pr_taken", state_dbg, CLK_ON);
    wait_state(IDLE, 80, "t3_back_idle");
    check("t3_one_done", done_count - base, 1);
    check("t3_others_stable", others_bad, 0);

    // reset in WAIT_PR abandons the sequence
    sel_mask = 3'b100; others_bad = 1'b0;
    send_req(2, 0);
    wait_state(WAIT_PR, 20, "t4_reach_wait_pr");
    exp_q.delete();
    base = done_count;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("t4_rst_state", state_dbg, IDLE);
    check("t4_rst_outputs", {decouple, slot_clken, slot_resetn}, 9'b000_111_111);
    check("t4_rst_flags", {busy, done_valid, done_err, req_ready}, 0);
    repeat (3) @(posedge clk);
    release_reset("t4");
    check("t4_no_done", done_count - base, 0);

    // stalled lock on slot 1
    sel_mask = 3'b010; others_bad = 1'b0; lock_inhibit = 3'b010; base = done_count;
`ifdef SLOT_SEQ_TIMEOUT_EN
    send_req(1, 1);
`else
    send_req(1, 0);
`endif
    wait_state(WAIT_PR, 20, "t5_reach_wait_pr");
    pulse_pr();
    check("t5_clk_on", state_dbg, CLK_ON);
`ifdef SLOT_SEQ_TIMEOUT_EN
    repeat (1023) @(negedge clk);
    check("t5_before_timeout", {state_dbg == CLK_ON, done_valid}, 2'b10);
    @(negedge clk);
    check("t5_timeout_done", {done_valid, done_err, done_slot}, {1'b1, 1'b1, 4'd1});
    check("t5_slot_parked", {decouple, slot_clken, slot_resetn}, 9'b010_101_101);
    @(negedge clk);
    check("t5_idle_after_timeout", state_dbg, IDLE);
`else
    repeat (1100) @(negedge clk);
    check("t5_unbounded_wait", state_dbg, CLK_ON);
    check("t5_no_done_while_waiting", done_count - base, 0);
    lock_inhibit = 3'b000;
    wait_state(IDLE, 80, "t5_back_idle");
    check("t5_final_outputs", {decouple, slot_clken, slot_resetn}, 9'b000_111_111);
`endif
    check("t5_one_done", done_count - base, 1);
    check("t5_others_stable", others_bad, 0);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
